// File: rtl/bram_fifo_pkg.sv
// Shared constants and helpers for the BRAM-backed FIFO controller.
// Defining BRAM_FIFO_CTRL_PARITY_EN widens the BRAM word by one even-parity bit.
package bram_fifo_pkg;

  localparam int SKID_DEPTH = 2;
  localparam int PAR_MAX_W  = 256;

`ifdef BRAM_FIFO_CTRL_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  function automatic int fifo_depth(input int aw);
    return 1 << aw;
  endfunction

  // One extra bit distinguishes full from empty when the pointers wrap.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // XOR-reduce: the bit that makes the total count of ones even.
  function automatic logic parity_of(input logic [PAR_MAX_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/bram_fifo_skid.sv
// Two-entry register FIFO holding words fetched from the BRAM; head_o is
// always the oldest entry.
module bram_fifo_skid
  import bram_fifo_pkg::*;
#(
  parameter int W = 36
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         valid_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] e0_q, e0_d, e1_q, e1_d;
  logic [1:0]   cnt_q, cnt_d, slot;
  logic         do_push, do_pop;

  assign do_pop  = pop_i && (cnt_q != 2'd0);
  assign do_push = push_i && ((cnt_q != 2'(SKID_DEPTH)) || do_pop);
  assign slot    = do_pop ? cnt_q - 2'd1 : cnt_q;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    e0_d  = e0_q;
    e1_d  = e1_q;
    cnt_d = cnt_q;
    if (do_pop) begin
      e0_d = e1_q;
    end
    if (do_push) begin
      if (slot == 2'd0) e0_d = data_i;
      else              e1_d = data_i;
    end
    if (do_push && !do_pop)      cnt_d = cnt_q + 2'd1;
    else if (!do_push && do_pop) cnt_d = cnt_q - 2'd1;
  end

  // NOTE: the two storage words are reset (unlike the BRAM array) because the
  // head must read as zero while reset is held; they are only two registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      cnt_q <= cnt_d;
    end
  end

  assign head_o  = e0_q;
  assign valid_o = (cnt_q != 2'd0);
  assign count_o = cnt_q;

endmodule

// File: rtl/bram_fifo_ctrl.sv
// Streaming FIFO controller over a dual-port BRAM (port A writes, port B reads)
// with a 2-entry skid. Optional parity: BRAM_FIFO_CTRL_PARITY_EN.
module bram_fifo_ctrl
  import bram_fifo_pkg::*;
#(
  parameter  int data_w = 36,
  parameter  int addr_w = 9,
  localparam int BRAM_W = data_w + PAR_BITS,
  localparam int CNT_W  = addr_w + 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              WR_VALID,
  output logic              WR_READY,
  input  logic [data_w-1:0] WR_DATA,
  output logic              RD_VALID,
  input  logic              RD_READY,
  output logic [data_w-1:0] RD_DATA,
  output logic [CNT_W-1:0]  COUNT,
  output logic              BRAM_ENA,
  output logic              BRAM_WEA,
  output logic [addr_w-1:0] BRAM_ADDRA,
  output logic [BRAM_W-1:0] BRAM_DIA,
  output logic              BRAM_ENB,
  output logic              BRAM_WEB,
  output logic              BRAM_SSRB,
  output logic [addr_w-1:0] BRAM_ADDRB,
  input  logic [BRAM_W-1:0] BRAM_DOB
`ifdef BRAM_FIFO_CTRL_PARITY_EN
  ,
  output logic              RD_PERR
`endif
);

  localparam int DEPTH = fifo_depth(addr_w);
  localparam int PTR_W = ptr_width(DEPTH);

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, mem_cnt_q, mem_cnt_d;
  logic              inflight_q, rst_done_q;
  logic              push, pop, fetch;
  logic [2:0]        occ;
  logic [1:0]        skid_cnt;
  logic              skid_valid;
  logic [BRAM_W-1:0] skid_din, skid_head;

  assign WR_READY = rst_done_q && (mem_cnt_q != PTR_W'(DEPTH));
  assign push     = WR_VALID && WR_READY;
  assign pop      = skid_valid && RD_READY;

  // Fetch only if the word will find a free skid slot when it lands next cycle.
  // mem_cnt_q is the registered count, so a word is never read in its write cycle.
  assign occ   = {1'b0, skid_cnt} + {2'b00, inflight_q};
  assign fetch = (mem_cnt_q != '0) && (occ < (3'd2 + {2'b00, pop}));

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    mem_cnt_d = mem_cnt_q;
    if (push)  wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (fetch) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !fetch)      mem_cnt_d = mem_cnt_q + PTR_W'(1);
    else if (!push && fetch) mem_cnt_d = mem_cnt_q - PTR_W'(1);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      mem_cnt_q  <= '0;
      inflight_q <= 1'b0;
      rst_done_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      mem_cnt_q  <= mem_cnt_d;
      inflight_q <= fetch;
      rst_done_q <= 1'b1;
    end
  end

  assign BRAM_ENA   = push;
  assign BRAM_WEA   = push;
  assign BRAM_ADDRA = wr_ptr_q[addr_w-1:0];
  assign BRAM_ENB   = 1'b0;
  assign BRAM_WEB   = 1'b0;
  assign BRAM_SSRB  = RST;
  // DOB is re-registered every edge, so the read address must always be rd_ptr.
  assign BRAM_ADDRB = rd_ptr_q[addr_w-1:0];

`ifdef BRAM_FIFO_CTRL_PARITY_EN
  // The skid stores the parity-check result in place of the parity bit.
  assign BRAM_DIA = {parity_of(PAR_MAX_W'(WR_DATA)), WR_DATA};
  assign skid_din = {parity_of(PAR_MAX_W'(BRAM_DOB)), BRAM_DOB[data_w-1:0]};
  assign RD_PERR  = skid_valid && skid_head[data_w];
`else
  assign BRAM_DIA = WR_DATA;
  assign skid_din = BRAM_DOB;
`endif

  bram_fifo_skid #(
    .W(BRAM_W)
  ) u_skid (
    .clk_i  (CLK),
    .rst_i  (RST),
    .push_i (inflight_q),
    .data_i (skid_din),
    .pop_i  (pop),
    .head_o (skid_head),
    .valid_o(skid_valid),
    .count_o(skid_cnt)
  );

  assign RD_VALID = skid_valid;
  assign RD_DATA  = skid_head[data_w-1:0];
  assign COUNT    = CNT_W'(mem_cnt_q) + CNT_W'(inflight_q) + CNT_W'(skid_cnt);

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Directed testbench for bram_fifo_ctrl with a behavioural dual-port BRAM model.
// The parity scenario runs only when BRAM_FIFO_CTRL_PARITY_EN is defined.
module tb_bram_fifo_ctrl;

  localparam int DW    = 36;
  localparam int AW    = 9;
  localparam int DEPTH = 1 << AW;
`ifdef BRAM_FIFO_CTRL_PARITY_EN
  localparam int BW = DW + 1;
`else
  localparam int BW = DW;
`endif

  logic          CLK = 1'b0, RST = 1'b0, WR_VALID = 1'b0, RD_READY = 1'b0;
  logic [DW-1:0] WR_DATA = '0;
  logic          WR_READY, RD_VALID;
  logic [DW-1:0] RD_DATA;
  logic [AW+1:0] COUNT;
  logic          BRAM_ENA, BRAM_WEA, BRAM_ENB, BRAM_WEB, BRAM_SSRB;
  logic [AW-1:0] BRAM_ADDRA, BRAM_ADDRB;
  logic [BW-1:0] BRAM_DIA, BRAM_DOB;
`ifdef BRAM_FIFO_CTRL_PARITY_EN
  logic          RD_PERR;
`endif

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] next_data = 36'h0_0000_1000;
  logic [DW-1:0] exp_q[$];

  bram_fifo_ctrl #(.data_w(DW), .addr_w(AW)) dut (
    .CLK(CLK), .RST(RST),
    .WR_VALID(WR_VALID), .WR_READY(WR_READY), .WR_DATA(WR_DATA),
    .RD_VALID(RD_VALID), .RD_READY(RD_READY), .RD_DATA(RD_DATA),
    .COUNT(COUNT),
    .BRAM_ENA(BRAM_ENA), .BRAM_WEA(BRAM_WEA), .BRAM_ADDRA(BRAM_ADDRA), .BRAM_DIA(BRAM_DIA),
    .BRAM_ENB(BRAM_ENB), .BRAM_WEB(BRAM_WEB), .BRAM_SSRB(BRAM_SSRB),
    .BRAM_ADDRB(BRAM_ADDRB), .BRAM_DOB(BRAM_DOB)
`ifdef BRAM_FIFO_CTRL_PARITY_EN
    , .RD_PERR(RD_PERR)
`endif
  );

  always #5 CLK = ~CLK;

  // BRAM model: port A write, DOB re-registered every edge, SSRB clears DOB.
  logic [BW-1:0] mem [DEPTH];
  logic [BW-1:0] flip_mask = '0;
  logic [AW-1:0] flip_addr = '0;
  always @(posedge CLK) begin
    if (BRAM_ENA && BRAM_WEA) mem[BRAM_ADDRA] <= BRAM_DIA;
    if (BRAM_SSRB) BRAM_DOB <= '0;
    else           BRAM_DOB <= mem[BRAM_ADDRB] ^ ((BRAM_ADDRB == flip_addr) ? flip_mask : '0);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One cycle from a negedge to the next; records accepted pushes and returns
  // the head word when a pop happens at the intervening posedge.
  task automatic step(input logic wv, input logic rr, output logic acc,
                      output logic popd, output logic [DW-1:0] pdata);
    WR_VALID = wv;
    RD_READY = rr;
    WR_DATA  = next_data;
    acc   = wv && WR_READY;
    popd  = rr && RD_VALID;
    pdata = RD_DATA;
    if (acc) begin
      exp_q.push_back(next_data);
      next_data = next_data + 36'd1;
    end
    @(negedge CLK);
  endtask

  task automatic test_reset();
    #1 RST = 1'b1;
    #11;
    total++; if (WR_READY !== 1'b0) begin bad++; $display("FAIL rst_wr_ready: got %b want 0", WR_READY); end
    total++; if (RD_VALID !== 1'b0) begin bad++; $display("FAIL rst_rd_valid: got %b want 0", RD_VALID); end
    total++; if (RD_DATA !== '0) begin bad++; $display("FAIL rst_rd_data: got %h want 0", RD_DATA); end
    total++; if (COUNT !== '0) begin bad++; $display("FAIL rst_count: got %0d want 0", COUNT); end
    total++; if (BRAM_SSRB !== 1'b1) begin bad++; $display("FAIL rst_ssrb: got %b want 1", BRAM_SSRB); end
    total++; if ({BRAM_ENA, BRAM_WEA, BRAM_ENB, BRAM_WEB} !== 4'b0) begin
      bad++; $display("FAIL rst_enables: got %b want 0000", {BRAM_ENA, BRAM_WEA, BRAM_ENB, BRAM_WEB});
    end
    @(negedge CLK);
    RST = 1'b0;
    #1;
    total++; if (WR_READY !== 1'b0) begin bad++; $display("FAIL rel_wr_ready_pre_edge: got %b want 0", WR_READY); end
    total++; if (BRAM_SSRB !== 1'b0) begin bad++; $display("FAIL rel_ssrb: got %b want 0", BRAM_SSRB); end
    @(negedge CLK);
    total++; if (WR_READY !== 1'b1) begin bad++; $display("FAIL rel_wr_ready_first_edge: got %b want 1", WR_READY); end
  endtask

  task automatic test_single_push();
    WR_VALID = 1'b1;
    WR_DATA  = 36'h1_2345_6789;
    #1;
    total++; if ({BRAM_ENA, BRAM_WEA} !== 2'b11) begin bad++; $display("FAIL single_ena_wea: got %b want 11", {BRAM_ENA, BRAM_WEA}); end
    total++; if (BRAM_ADDRA !== 9'd0) begin bad++; $display("FAIL single_addra: got %0d want 0", BRAM_ADDRA); end
    total++; if (BRAM_DIA[DW-1:0] !== 36'h1_2345_6789) begin bad++; $display("FAIL single_dia: got %h want 123456789", BRAM_DIA[DW-1:0]); end
    @(negedge CLK);
    WR_VALID = 1'b0;
    total++; if (RD_VALID !== 1'b0 || COUNT !== 11'd1) begin bad++; $display("FAIL single_edge1: valid=%b count=%0d want 0/1", RD_VALID, COUNT); end
    @(negedge CLK);
    total++; if (RD_VALID !== 1'b0 || COUNT !== 11'd1) begin bad++; $display("FAIL single_edge2: valid=%b count=%0d want 0/1", RD_VALID, COUNT); end
    @(negedge CLK);
    total++; if (RD_VALID !== 1'b1) begin bad++; $display("FAIL single_latency: valid=%b want 1", RD_VALID); end
    total++; if (RD_DATA !== 36'h1_2345_6789) begin bad++; $display("FAIL single_data: got %h want 123456789", RD_DATA); end
    total++; if (COUNT !== 11'd1) begin bad++; $display("FAIL single_count: got %0d want 1", COUNT); end
    RD_READY = 1'b1;
    @(negedge CLK);
    RD_READY = 1'b0;
    total++; if (RD_VALID !== 1'b0 || COUNT !== 11'd0) begin bad++; $display("FAIL single_pop: valid=%b count=%0d want 0/0", RD_VALID, COUNT); end
  endtask

  task automatic test_stream();
    logic acc, popd;
    logic [DW-1:0] pd, exp;
    int sent = 0, got = 0, first = -1;
    for (int cyc = 0; cyc < 1100 && got < 1000; cyc++) begin
      step(sent < 1000, 1'b1, acc, popd, pd);
      if (sent < 1000) begin
        total++; if (!acc) begin bad++; $display("FAIL stream_wr_ready: cycle %0d push refused", cyc); end
      end
      if (acc) sent++;
      if (got > 0) begin
        total++; if (!popd) begin bad++; $display("FAIL stream_bubble: cycle %0d no pop after %0d words", cyc, got); end
      end
      if (popd) begin
        if (first < 0) first = cyc;
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL stream_extra_pop: got %h want no word", pd);
        end else begin
          exp = exp_q.pop_front();
          if (pd !== exp) begin bad++; $display("FAIL stream_data: got %h want %h", pd, exp); end
        end
        got++;
      end
    end
    WR_VALID = 1'b0;
    RD_READY = 1'b0;
    total++; if (first !== 3) begin bad++; $display("FAIL stream_first_pop: cycle %0d want 3", first); end
    total++; if (got !== 1000) begin bad++; $display("FAIL stream_word_count: got %0d want 1000", got); end
    total++; if (COUNT !== 11'd0) begin bad++; $display("FAIL stream_end_count: got %0d want 0", COUNT); end
  endtask

  task automatic drain(input int want, input string tag);
    logic acc, popd;
    logic [DW-1:0] pd, exp;
    int got = 0;
    for (int cyc = 0; cyc < 700 && exp_q.size() > 0; cyc++) begin
      step(1'b0, 1'b1, acc, popd, pd);
      if (popd) begin
        exp = exp_q.pop_front();
        total++; if (pd !== exp) begin bad++; $display("FAIL %s_data: got %h want %h", tag, pd, exp); end
        got++;
      end
    end
    RD_READY = 1'b0;
    #1;
    total++; if (got !== want) begin bad++; $display("FAIL %s_words: got %0d want %0d", tag, got, want); end
    total++; if (COUNT !== 11'd0 || RD_VALID !== 1'b0) begin
      bad++; $display("FAIL %s_empty: count=%0d valid=%b want 0/0", tag, COUNT, RD_VALID);
    end
    @(negedge CLK);
  endtask

  task automatic test_fill_drain();
    logic acc, popd;
    logic [DW-1:0] pd;
    int n = 0;
    for (int i = 0; i < 600; i++) begin
      step(1'b1, 1'b0, acc, popd, pd);
      if (acc) n++;
      else break;
    end
    total++; if (n !== DEPTH + 2) begin bad++; $display("FAIL fill_accepted: got %0d want 514", n); end
    total++; if (COUNT !== 11'd514) begin bad++; $display("FAIL fill_count: got %0d want 514", COUNT); end
    total++; if (WR_READY !== 1'b0 || RD_VALID !== 1'b1) begin
      bad++; $display("FAIL fill_flags: ready=%b valid=%b want 0/1", WR_READY, RD_VALID);
    end
    WR_VALID = 1'b1;
    #1;
    total++; if (BRAM_ENA !== 1'b0) begin bad++; $display("FAIL full_push_ena: got %b want 0", BRAM_ENA); end
    step(1'b1, 1'b0, acc, popd, pd);
    WR_VALID = 1'b0;
    total++; if (COUNT !== 11'd514 || acc) begin bad++; $display("FAIL full_push_ignored: count=%0d acc=%b want 514/0", COUNT, acc); end
    drain(DEPTH + 2, "fill_drain");
  endtask

  task automatic test_boundary();
    logic acc, popd;
    logic [DW-1:0] pd, exp;
    int n = 0;
    for (int i = 0; i < 600 && n < DEPTH + 1; i++) begin
      step(1'b1, 1'b0, acc, popd, pd);
      if (acc) n++;
    end
    repeat (3) step(1'b0, 1'b0, acc, popd, pd);
    total++; if (COUNT !== 11'd513 || WR_READY !== 1'b1) begin
      bad++; $display("FAIL bnd_513: count=%0d ready=%b want 513/1", COUNT, WR_READY);
    end
    step(1'b1, 1'b0, acc, popd, pd);
    total++; if (COUNT !== 11'd514 || WR_READY !== 1'b0) begin
      bad++; $display("FAIL bnd_full: count=%0d ready=%b want 514/0", COUNT, WR_READY);
    end
    step(1'b1, 1'b1, acc, popd, pd);
    exp = exp_q.pop_front();
    total++; if (acc || !popd || pd !== exp) begin
      bad++; $display("FAIL bnd_pop_at_full: acc=%b pop=%b data=%h want 0/1/%h", acc, popd, pd, exp);
    end
    total++; if (COUNT !== 11'd513 || WR_READY !== 1'b1) begin
      bad++; $display("FAIL bnd_reopen: count=%0d ready=%b want 513/1", COUNT, WR_READY);
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, acc, popd, pd);
      exp = exp_q.pop_front();
      total++; if (!acc || !popd || pd !== exp) begin
        bad++; $display("FAIL bnd_pushpop: acc=%b pop=%b data=%h want 1/1/%h", acc, popd, pd, exp);
      end
      total++; if (COUNT !== 11'd513 || WR_READY !== 1'b1) begin
        bad++; $display("FAIL bnd_steady: count=%0d ready=%b want 513/1", COUNT, WR_READY);
      end
    end
    step(1'b1, 1'b0, acc, popd, pd);
    total++; if (COUNT !== 11'd514 || WR_READY !== 1'b0) begin
      bad++; $display("FAIL bnd_refill: count=%0d ready=%b want 514/0", COUNT, WR_READY);
    end
    WR_VALID = 1'b0;
    drain(DEPTH + 2, "bnd_drain");
  endtask

  task automatic test_reset_midstream();
    logic acc, popd;
    logic [DW-1:0] pd, exp;
    repeat (5) step(1'b1, 1'b0, acc, popd, pd);
    step(1'b0, 1'b0, acc, popd, pd);
    total++; if (COUNT !== 11'd5) begin bad++; $display("FAIL mid_pre_count: got %0d want 5", COUNT); end
    #2;
    RD_READY = 1'b1;
    RST = 1'b1;
    #1;
    total++; if (RD_VALID !== 1'b0 || RD_DATA !== '0) begin
      bad++; $display("FAIL mid_async_out: valid=%b data=%h want 0/0", RD_VALID, RD_DATA);
    end
    total++; if (COUNT !== 11'd0 || WR_READY !== 1'b0) begin
      bad++; $display("FAIL mid_async_cnt: count=%0d ready=%b want 0/0", COUNT, WR_READY);
    end
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    RD_READY = 1'b0;
    exp_q.delete();
    #1;
    total++; if (COUNT !== 11'd0 || RD_VALID !== 1'b0) begin
      bad++; $display("FAIL mid_release: count=%0d valid=%b want 0/0", COUNT, RD_VALID);
    end
    @(negedge CLK);
    step(1'b1, 1'b0, acc, popd, pd);
    total++; if (!acc) begin bad++; $display("FAIL mid_push_after: push refused"); end
    repeat (2) step(1'b0, 1'b0, acc, popd, pd);
    step(1'b0, 1'b1, acc, popd, pd);
    exp = exp_q.pop_front();
    total++; if (!popd || pd !== exp) begin bad++; $display("FAIL mid_pop_after: pop=%b data=%h want 1/%h", popd, pd, exp); end
    total++; if (COUNT !== 11'd0) begin bad++; $display("FAIL mid_final_count: got %0d want 0", COUNT); end
    RD_READY = 1'b0;
  endtask

`ifdef BRAM_FIFO_CTRL_PARITY_EN
  task automatic test_parity();
    logic acc, popd;
    logic [DW-1:0] pd;
    // After the previous test rd_ptr sits at 1: words land at addresses 1,2,3.
    flip_addr = 9'd2;
    flip_mask = BW'(16);
    repeat (3) step(1'b1, 1'b0, acc, popd, pd);
    repeat (3) step(1'b0, 1'b0, acc, popd, pd);
    total++; if (RD_PERR !== 1'b0) begin bad++; $display("FAIL par_word0: perr=%b want 0", RD_PERR); end
    step(1'b0, 1'b1, acc, popd, pd);
    void'(exp_q.pop_front());
    total++; if (RD_PERR !== 1'b1) begin bad++; $display("FAIL par_word1: perr=%b want 1", RD_PERR); end
    step(1'b0, 1'b1, acc, popd, pd);
    void'(exp_q.pop_front());
    total++; if (RD_PERR !== 1'b0 || RD_VALID !== 1'b1) begin
      bad++; $display("FAIL par_word2: perr=%b valid=%b want 0/1", RD_PERR, RD_VALID);
    end
    step(1'b0, 1'b1, acc, popd, pd);
    void'(exp_q.pop_front());
    RD_READY = 1'b0;
    flip_mask = '0;
    total++; if (RD_PERR !== 1'b0 || COUNT !== 11'd0) begin
      bad++; $display("FAIL par_empty: perr=%b count=%0d want 0/0", RD_PERR, COUNT);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_push();
    test_stream();
    test_fill_drain();
    test_boundary();
    test_reset_midstream();
`ifdef BRAM_FIFO_CTRL_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bram_fifo_ctrl.md
Name: bram_fifo_ctrl

Overview:
- Synchronous FIFO controller that sits directly upstream of the dual-port block-RAM model.
- Drives BRAM port A as the write port and port B as the read port.
- Consumes the BRAM's registered DOB output into a 2-entry output skid buffer.
- Presents valid/ready streaming interfaces on both sides and sustains full throughput (1 push + 1 pop per cycle) despite the 1-cycle BRAM read latency.

Parameters:
- data_w, 36: payload width; equals the BRAM data_w (data_w+1 with the parity feature enabled).
- addr_w, 9: BRAM address width; memory depth DEPTH = 2**addr_w.

Ports:
- CLK  in  1  single clock; drives both BRAM CLKA and CLKB.
- RST  in  1  asynchronous, active-high reset.
- WR_VALID  in  1  push request.
- WR_READY  out  1  push accepted when WR_VALID & WR_READY at a rising edge.
- WR_DATA  in  data_w  push payload.
- RD_VALID  out  1  head entry available.
- RD_READY  in  1  pop when RD_VALID & RD_READY at a rising edge.
- RD_DATA  out  data_w  head payload.
- COUNT  out  addr_w+2  total entries held (BRAM + in-flight + skid).
- BRAM_ENA  out  1  port A enable (= push).
- BRAM_WEA  out  1  port A write enable (= push).
- BRAM_ADDRA  out  addr_w  write pointer.
- BRAM_DIA  out  data_w (+1 with parity)  write data.
- BRAM_ENB  out  1  tied 0 (port B never writes).
- BRAM_WEB  out  1  tied 0.
- BRAM_SSRB  out  1  = RST.
- BRAM_ADDRB  out  addr_w  read pointer.
- BRAM_DOB  in  data_w (+1 with parity)  registered read data.
- RD_PERR  out  1  parity-error flag (parity build only).

Behaviour:
- Reset: RST is asynchronous and active-high. While RST is high:
  - wr_ptr, rd_ptr, mem_cnt, fetch_inflight and skid count are 0.
  - WR_READY=0, RD_VALID=0, RD_DATA=0, COUNT=0, RD_PERR=0.
  - All BRAM enables are 0 and BRAM_SSRB=1. BRAM contents are not cleared.
  - On the first edge after RST falls, WR_READY=1.
- Reset mid-operation: all in-flight and skid data is discarded; no pop is generated.
- Pointers: addr_w+1 bits each, wrapping mod 2*DEPTH. The BRAM address is the low addr_w bits. mem_cnt = entries written but not yet fetched, range 0..DEPTH.
- Push: WR_READY = (mem_cnt != DEPTH). On a push:
  - BRAM_ENA=BRAM_WEA=1 combinationally, BRAM_ADDRA=wr_ptr, BRAM_DIA=WR_DATA.
  - wr_ptr increments.
  - Pushes with WR_READY=0 are ignored and leave state unchanged.
- Fetch, issued in cycle t when mem_cnt_q>0 and (skid_cnt + fetch_inflight − pop_this_cycle) < 2:
  - BRAM_ADDRB = rd_ptr, so the BRAM captures MEM[rd_ptr] at the end of t.
  - rd_ptr increments, mem_cnt decrements, fetch_inflight is set for cycle t+1.
  - In t+1, BRAM_DOB is written into the skid.
- BRAM_ADDRB must hold rd_ptr at all times. The BRAM re-registers DOB every edge regardless of enable, so an in-flight word is valid only in the cycle directly after its fetch.
- Read/write same address: a fetch uses registered mem_cnt_q, so a word pushed at edge k is never fetched before cycle k+1. This avoids the BRAM old-data hazard on the same address.
- Simultaneous push and fetch: mem_cnt is unchanged; COUNT = +1 push −1 pop.
- Latency: push at edge k → RD_VALID=1 after edge k+2 when the FIFO is empty.
- Throughput: 1 word/cycle steady state with RD_READY=1.
- Skid: 2-entry register FIFO; RD_DATA is always the head.
- RD_READY low: the skid fills to 2, fetches stop, the BRAM absorbs further pushes up to DEPTH, then WR_READY drops. Total capacity is DEPTH+2.
- Pop on an empty FIFO (RD_VALID=0) is ignored.

Optional Feature:
- Macro: BRAM_FIFO_CTRL_PARITY_EN.
- When defined:
  - The BRAM word is data_w+1 wide; bit data_w holds even parity of WR_DATA.
  - On skid write, parity is rechecked.
  - RD_PERR is a registered flag aligned with the head entry: high while the head entry has bad parity, cleared when it pops.
- When undefined: BRAM width = data_w, the RD_PERR port is absent, and no parity logic is built.

Decomposition:
- Package bram_fifo_pkg:
  - ptr width function clog2-style.
  - DEPTH localparam helper.
  - Skid depth constant SKID_DEPTH=2.
  - Parity function.
- One sub-module: bram_fifo_skid (2-entry register FIFO with count output and push/pop), instantiated for the output side.

Test Plan:
- Reset then single push of 0x123456789 → RD_VALID rises exactly 2 edges later with RD_DATA=0x123456789; COUNT 1→0 on pop.
- Continuous push/pop with RD_READY=1 for 1000 words (incrementing data) → no bubbles after the first 2 cycles; output sequence is identical.
- RD_READY=0, push until WR_READY=0 → accepted count = 2**addr_w+2 (514); COUNT=514; drain returns the data in order, wrapping pointers.
- Push to empty and pop in the same cycles at a full-minus-1 boundary → WR_READY toggles correctly; no lost or duplicated word at pointer wrap 511→0.
- Assert RST mid-stream with 5 words in the skid/BRAM → outputs go to 0 immediately (asynchronously); after release COUNT=0, RD_VALID=0, and the next push/pop works.
- Parity build: force a BRAM_DOB bit flip on one word → RD_PERR=1 only while that word is head; other words show RD_PERR=0.
